basic_seq_ctrl: RTL
===================

BASIC_SEQ_CTRL -- requirements
Module: basic_seq_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port en, input, 1: clock enable; when 0, all state is frozen and all strobes are 0.
REQ-004 SHALL have port start, input, 1: pulse that sets the run flag.
REQ-005 SHALL have port halt, input, 1: request to stop at the end of the current instruction.
REQ-006 SHALL have ports opc, input, 3, and ind, input, 1: the opcode (IR[14:12]) and indirect bit (IR[15]).
REQ-007 SHALL have port dr_zero, input, 1: DR == 0 after increment.
REQ-008 SHALL have port mem_rdy, input, 1: memory access complete.
REQ-009 SHALL have port t, output, 16: one-hot timing signals T0..T15.
REQ-010 SHALL have port sc, output, 4: sequence count.
REQ-011 SHALL have port running, output, 1: the run flag.
REQ-012 SHALL have port bus_sel, output, 3: bus source (1=AR, 2=PC, 3=DR, 4=AC, 5=IR, 7=MEM, 0=none).
REQ-013 SHALL have strobe outputs, 1 bit each: ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld, mem_rd, mem_wr, reg_exec.
REQ-014 SHALL have port alu_op, output, 2: 0=AND, 1=ADD, 2=PASS DR.

Function
REQ-015 SHALL hold a 4-bit SC and drive t = one-hot decode of SC; exactly one bit of t SHALL be set at all times.
REQ-016 With running=0: SC SHALL hold at 0 and all strobes SHALL be 0; start=1 SHALL set running, with fetch beginning the next cycle.
REQ-017 Strobes SHALL be combinational from SC, opc, ind, dr_zero and mem_rdy, and SHALL be gated by running and en.
REQ-018 T0: bus_sel=2, ar_ld.
REQ-019 T1: bus_sel=7, mem_rd, ir_ld, pc_inc.
REQ-020 T2: bus_sel=5, ar_ld.
REQ-021 T3:
- opc=7: reg_exec, then SC<=0.
- opc!=7 and ind=1: bus_sel=7, mem_rd, ar_ld.
- opc!=7 and ind=0: idle cycle.
REQ-022 Execute phase, with SC cleared at the end of each instruction:
- AND/ADD/LDA (opc 0/1/2): T4 dr_ld from MEM; T5 ac_ld with alu_op = 0/1/2, then SC<=0.
- STA (3): T4 bus_sel=4, mem_wr, then SC<=0.
- BUN (4): T4 bus_sel=1, pc_ld, then SC<=0.
- BSA (5): T4 bus_sel=2, mem_wr, ar_inc; T5 bus_sel=1, pc_ld, then SC<=0.
- ISZ (6): T4 dr_ld from MEM; T5 dr_inc; T6 bus_sel=3, mem_wr, pc_inc if dr_zero, then SC<=0.
REQ-023 In all other cycles SC SHALL increment; SC SHALL never exceed 6 while running; an illegal SC value SHALL force SC<=0 next cycle.
REQ-024 halt=1 SHALL be latched into a pending flag; at the next end-of-instruction SC clear, running SHALL go to 0.
REQ-025 halt=1 while running=0 SHALL be ignored.
REQ-026 start=1 while running=1 SHALL be ignored.
REQ-027 If halt=1 and start=1 arrive in the same cycle while stopped, start wins and halt is dropped.

Reset
REQ-028 reset=1 SHALL, on the next edge, set SC=0 (t=16'h0001), running=0 and halt-pending=0, regardless of en or mid-instruction state.
REQ-029 All strobes SHALL be 0 and bus_sel SHALL be 0 while running=0.

Configuration
REQ-030 Macro SEQ_MEM_WAIT_EN SHALL select the memory wait behaviour.
- When defined: in any cycle asserting mem_rd or mem_wr with mem_rdy=0, SC SHALL hold; load/inc strobes in that cycle SHALL be 0; mem_rd/mem_wr and bus_sel SHALL stay asserted until mem_rdy=1, and the cycle completes then.
- When undefined: mem_rdy SHALL be ignored and every memory cycle completes in one clock.

Verification
REQ-031 Reset, then start=1, then opc=2, ind=0, mem_rdy=1 -> t walks T0..T5; T5 shows ac_ld with alu_op=2; the next cycle is T0.
REQ-032 opc=6, ind=1, dr_zero=1 -> T3 shows mem_rd+ar_ld; T6 shows mem_wr+pc_inc with bus_sel=3; total 7 cycles.
REQ-033 halt=1 pulsed at T4 of a BSA (opc=5) -> T5 completes, then running=0 with t held at T0.
REQ-034 With SEQ_MEM_WAIT_EN defined, mem_rdy=0 for 3 cycles at T1 -> t stays at T1 for 4 cycles; ir_ld/pc_inc fire only in the last of them.
REQ-035 reset=1 at T5 of an ADD -> next cycle sc=0, running=0, no strobes; en=0 for 2 cycles mid-instruction -> sc unchanged and strobes 0.

Source files
------------

// File: rtl/basic_seq_ctrl.sv
// Timing/control sequencer for a basic accumulator CPU: SC counter, run flag and strobe decode.
// Optional macro SEQ_MEM_WAIT_EN stretches memory cycles until mem_rdy; undefined = single-cycle memory.
module basic_seq_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic        halt,
  input  logic [2:0]  opc,
  input  logic        ind,
  input  logic        dr_zero,
  input  logic        mem_rdy,
  output logic [15:0] t,
  output logic [3:0]  sc,
  output logic        running,
  output logic [2:0]  bus_sel,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_exec,
  output logic [1:0]  alu_op
);

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} run_e;

  run_e       run_q, run_d;
  logic [3:0] sc_q, sc_d;
  logic       halt_q, halt_d;
  logic       active;
  logic       eoi;
  logic       stall;

`ifndef SEQ_MEM_WAIT_EN
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
`endif

  always_comb begin
    bus_sel  = BUS_NONE;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_exec = 1'b0;
    alu_op   = 2'd0;
    eoi      = 1'b0;
    stall    = 1'b0;
    active   = (run_q == ST_RUN) && en;

    if (active) begin
      case (sc_q)
        4'd0: begin bus_sel = BUS_PC; ar_ld = 1'b1; end
        4'd1: begin bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
        4'd2: begin bus_sel = BUS_IR; ar_ld = 1'b1; end
        4'd3: begin
          if (opc == 3'd7) begin
            reg_exec = 1'b1;
            eoi      = 1'b1;
          end else if (ind) begin
            bus_sel = BUS_MEM; mem_rd = 1'b1; ar_ld = 1'b1;
          end
        end
        4'd4: begin
          case (opc)
            3'd0, 3'd1, 3'd2, 3'd6: begin bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1; end
            3'd3: begin bus_sel = BUS_AC; mem_wr = 1'b1; eoi = 1'b1; end
            3'd4: begin bus_sel = BUS_AR; pc_ld = 1'b1; eoi = 1'b1; end
            3'd5: begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_inc = 1'b1; end
            default: ;
          endcase
        end
        4'd5: begin
          case (opc)
            3'd0, 3'd1, 3'd2: begin ac_ld = 1'b1; alu_op = opc[1:0]; eoi = 1'b1; end
            3'd5: begin bus_sel = BUS_AR; pc_ld = 1'b1; eoi = 1'b1; end
            3'd6: dr_inc = 1'b1;
            default: ;
          endcase
        end
        4'd6: begin
          if (opc == 3'd6) begin
            bus_sel = BUS_DR; mem_wr = 1'b1; pc_inc = dr_zero; eoi = 1'b1;
          end
        end
        default: ;
      endcase
    end

`ifdef SEQ_MEM_WAIT_EN
    stall = (mem_rd | mem_wr) & ~mem_rdy;
`endif
    // A stalled memory cycle keeps its bus/mem strobes but commits nothing.
    if (stall) begin
      ar_ld  = 1'b0;
      ar_inc = 1'b0;
      pc_ld  = 1'b0;
      pc_inc = 1'b0;
      dr_ld  = 1'b0;
      dr_inc = 1'b0;
      ac_ld  = 1'b0;
      ir_ld  = 1'b0;
      eoi    = 1'b0;
    end

    run_d  = run_q;
    sc_d   = sc_q;
    halt_d = halt_q;
    if (en) begin
      if (run_q == ST_IDLE) begin
        sc_d = 4'd0;
        if (start) begin
          run_d  = ST_RUN;
          halt_d = 1'b0;
        end
      end else begin
        if (halt) halt_d = 1'b1;
        if (stall)                   sc_d = sc_q;
        else if (eoi || sc_q >= 4'd6) sc_d = 4'd0;
        else                         sc_d = sc_q + 4'd1;
        if (eoi && (halt_q || halt)) begin
          run_d  = ST_IDLE;
          halt_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q  <= ST_IDLE;
      sc_q   <= 4'd0;
      halt_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      sc_q   <= sc_d;
      halt_q <= halt_d;
    end
  end

  assign t       = 16'h0001 << sc_q;
  assign sc      = sc_q;
  assign running = (run_q == ST_RUN);

endmodule
